// File: rtl/call_pkg.sv
// Shared types and limits for the clocked call-channel responder blocks.
package call_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_e;

   localparam int SYNC_MIN    = 2;
   localparam int SYNC_MAX    = 4;
   localparam int ACK_DLY_MIN = 1;
   localparam int ACK_DLY_MAX = 255;
   localparam int ACK_CNT_W   = 8;

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser for an asynchronous level/transition input.
module sync_ff #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [N-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[N-2:0], din};
      end
   end

   assign dout = sync_q[N-1];

endmodule

// File: rtl/call_responder.sv
// Clocked server end of a 2-phase request/acknowledge channel: synchronises r,
// runs one service operation per request and toggles d when it completes.
module call_responder
   import call_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int AUTO_ACK    = 0,
   parameter int ACK_DLY     = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r,
   output logic             d,
   output logic             srv_start,
   input  logic             srv_done,
   output logic             busy,
   output logic [CNT_W-1:0] txn_count,
   output logic             proto_err
);

   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("call_responder: SYNC_STAGES out of range");
   end
   if (ACK_DLY < ACK_DLY_MIN || ACK_DLY > ACK_DLY_MAX) begin : g_bad_dly
      $error("call_responder: ACK_DLY out of range");
   end

   logic                 r_s;
   logic                 pend;
   state_e               state_q, state_d;
   logic                 d_q, d_d;
   logic                 start_q, start_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;
   logic [ACK_CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0]     txn_q, txn_d;

   sync_ff #(.N(SYNC_STAGES)) u_sync_r (
      .clk  (clk),
      .rst  (rst),
      .din  (r),
      .dout (r_s)
   );

   assign pend = r_s ^ d_q;

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      start_d = 1'b0;
      busy_d  = busy_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      txn_d   = txn_q;
      case (state_q)
         IDLE: begin
            if (pend) state_d = START;
         end
         START: begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = ACK_CNT_W'(ACK_DLY);
            state_d = WAIT;
         end
         WAIT: begin
            if (AUTO_ACK != 0) begin
               // Counter reaches zero ACK_DLY cycles after loading, then one more cycle to ACK.
               if (cnt_q == '0) state_d = ACK;
               else             cnt_d   = cnt_q - ACK_CNT_W'(1);
            end else if (srv_done) begin
               state_d = ACK;
            end
         end
         ACK: begin
            d_d     = ~d_q;
            txn_d   = txn_q + CNT_W'(1);
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A second r toggle before acknowledge makes r_s equal d while a request is in flight.
      if (state_q != IDLE && !pend) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         d_q     <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         txn_q   <= '0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         txn_q   <= txn_d;
      end
   end

   assign d         = d_q;
   assign srv_start = start_q;
   assign busy      = busy_q;
   assign txn_count = txn_q;
   assign proto_err = err_q;

endmodule

// File: doc/call_responder.md
Name: call_responder

Overview:
- Clocked server end of the 2-phase (transition-signalling) request/acknowledge channel driven by the call element's merged request `r` and acknowledge `d`.
- Synchronises the asynchronous request into the `clk` domain and starts a local service operation.
- When the service completes, it toggles acknowledge `d` back to the call element.
- Used wherever a call-merged shared resource is implemented in synchronous logic.

Parameters:
- SYNC_STAGES, 2, number of flops in the request synchroniser; legal range 2..4.
- AUTO_ACK, 0, 1 = ignore `srv_done` and acknowledge ACK_DLY cycles after `srv_start`; 0 = wait for `srv_done`.
- ACK_DLY, 4, auto-acknowledge delay in cycles; legal range 1..255; used only when AUTO_ACK=1.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  single clock for all state.
- rst  input  1  reset, asynchronous and active-high; forces every flop to its reset value.
- r  input  1  asynchronous 2-phase request; each transition is one request.
- d  output  1  2-phase acknowledge; toggles once per completed request; registered.
- srv_start  output  1  one-cycle pulse to local logic: service begins.
- srv_done  input  1  one-cycle pulse from local logic: service finished; ignored when AUTO_ACK=1.
- busy  output  1  high from the `srv_start` cycle through the `d`-toggle cycle.
- txn_count  output  CNT_W  number of completed transactions; wraps modulo 2^CNT_W.
- proto_err  output  1  sticky protocol-violation flag; cleared only by `rst`.

Behaviour:
- Reset values: d=0, srv_start=0, busy=0, txn_count=0, proto_err=0, all synchroniser flops=0, FSM=IDLE. The requester must be reset together with this block (r=0).
- r_s is the last synchroniser stage. A request is pending exactly when r_s != d.
- FSM states:
  - IDLE: if r_s != d, go to START; otherwise stay.
  - START: assert srv_start for exactly 1 cycle, set busy=1, load the delay counter with ACK_DLY; go to WAIT.
  - WAIT, AUTO_ACK=0: on srv_done=1, go to ACK.
  - WAIT, AUTO_ACK=1: decrement the counter each cycle; on reaching 0, go to ACK.
  - ACK: toggle d, increment txn_count, clear busy; go to IDLE.
- Latency:
  - r edge to srv_start high: SYNC_STAGES+1 cycles (r edge just before a clk edge counts as cycle 0).
  - srv_done to d toggle: 2 cycles (WAIT→ACK, then d registered).
  - AUTO_ACK: srv_start to d toggle = ACK_DLY+2 cycles.
- srv_done outside WAIT is ignored; it is neither stored nor counted.
- Back-to-back requests:
  - After the ACK cycle, the FSM sits in IDLE with r_s == d until the requester toggles r again.
  - The stale synchronised value can never create a phantom request, because d is updated in the same edge as the return to IDLE and r_s already equals the old r.
- Protocol violation: in START, WAIT or ACK, if r_s == d, the requester toggled twice without an acknowledge.
  - proto_err is set and stays set until reset.
  - The current transaction still completes normally.
  - The resulting r_s/d state then drives the next IDLE decision per the normal rule.
- txn_count wrap: 2^CNT_W-1 → 0 with no flag.
- Reset asserted mid-transaction: everything returns to reset values immediately; the in-flight request is lost; no srv_start glitch.
- No combinational path from any input to any output.

Decomposition:
- Package call_pkg:
  - FSM state enum {IDLE, START, WAIT, ACK};
  - constant SYNC_MIN=2;
  - width-check localparams for ACK_DLY.
- Sub-module sync_ff: parameterised N-stage synchroniser (clk, rst, din, dout), reset to 0. It is instantiated once for r and will be reused by other clocked async-channel blocks.

Test Plan:
- Single request, SYNC_STAGES=2, AUTO_ACK=0: toggle r 0→1; srv_start pulses at cycle 3; drive srv_done at cycle 6 → d=1 at cycle 8, txn_count=1, busy low at cycle 8.
- Back-to-back: 3 requests, each toggling r one cycle after d changes, srv_done 2 cycles after each srv_start → exactly 3 srv_start pulses, d sequence 1,0,1, txn_count=3, proto_err=0.
- AUTO_ACK=1, ACK_DLY=4: toggle r → d toggles 6 cycles after srv_start; srv_done pulses injected at random times have no effect.
- Protocol error: toggle r, then toggle it again 1 cycle after srv_start → proto_err=1 and d still toggles after srv_done. Reset → proto_err=0, d=0, txn_count=0.
- Reset mid-operation: assert rst while in WAIT → d, busy, srv_start go to 0 asynchronously; after release with r=0, no srv_start occurs for 20 cycles.
- Counter wrap, CNT_W=4: 17 transactions → txn_count=1; spurious srv_done in IDLE → no d change.
